bit_set_arbiter: RTL
====================

BIT_SET_ARBITER -- requirements
Module: bit_set_arbiter

Interface
REQ-001 Parameter: N, default 8, operand width and bit-index range; legal for N >= 2.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: req0_valid  input  1  requester 0 has an operation pending.
REQ-005 Port: req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-006 Port: req0_a / req0_b  input  N each  requester 0 value A and bit index B.
REQ-007 Port: req1_valid, req1_ready, req1_a, req1_b  same widths and meanings, requester 1.
REQ-008 Port: rsp_valid  output  1  response available.
REQ-009 Port: rsp_ready  input  1  consumer takes response when high with rsp_valid.
REQ-010 Port: rsp_id  output  1  index of the requester that owns the response.
REQ-011 Port: rsp_result  output  N  modified A.
REQ-012 Port: rsp_error  output  1  B was out of range.
REQ-013 Port: busy  output  1  high whenever the state is not IDLE.
REQ-014 Port: err_cnt  output  8  saturating count of error responses.
REQ-015 Port: err_clr  input  1  synchronous clear of err_cnt.

Function
REQ-016 The FSM SHALL have exactly three states, IDLE, EXEC and RESP, with transitions IDLE->EXEC on accept, EXEC->RESP unconditionally, and RESP->IDLE on rsp_valid&rsp_ready.
REQ-017 reqX_ready SHALL be high only in IDLE, only for the arbitration winner, and SHALL be combinational from the valids and the priority pointer.
REQ-018 Arbitration: if one valid is high, that requester SHALL win; if both are high, the requester indicated by the priority pointer SHALL win.
REQ-019 On accept, the pointer SHALL move to the non-served requester, and the winner's A, B and id SHALL be captured.
REQ-020 In EXEC, the block SHALL register the result: if B < N (B unsigned), result = A with bit B set and error = 0; otherwise result = A unchanged and error = 1.
REQ-021 Latency: for an accept at edge k, rsp_valid SHALL be high from edge k+2 onward, giving one operation per 3 cycles minimum.
REQ-022 rsp_valid SHALL be high only in RESP.
REQ-023 rsp_id, rsp_result and rsp_error SHALL remain stable while rsp_valid is high and not yet taken.
REQ-024 RESP SHALL hold indefinitely while rsp_ready is low.
REQ-025 No new request SHALL be accepted in EXEC or RESP.
REQ-026 The first accept is possible one cycle after the RESP->IDLE transition.
REQ-027 err_cnt SHALL increment on the EXEC->RESP edge when error = 1 and SHALL saturate at 255.
REQ-028 err_clr SHALL zero err_cnt on the next edge and SHALL win over a simultaneous increment.
REQ-029 Requester-side changes to a valid, A or B while that requester is not ready SHALL have no effect on state.

Reset
REQ-030 While rst is high, the block SHALL immediately hold: state IDLE, pointer = requester 0, rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_error = 0, busy = 0, err_cnt = 0.
REQ-031 A reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response issued.
REQ-032 After rst deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-033 N=8, only req0 valid with A=0x00, B=3 -> req0_ready high in IDLE; two edges later rsp_valid=1, rsp_id=0, rsp_result=0x08, rsp_error=0.
REQ-034 req0 and req1 held valid for 4 operations, rsp_ready=1 -> grants alternate 0,1,0,1; req1 with A=0xF0, B=0 returns 0xF1.
REQ-035 req1 with A=0x5A, B=8, then B=0xFF -> rsp_result=0x5A, rsp_error=1 each time; err_cnt=2.
REQ-036 rsp_ready held low 5 cycles in RESP, both valids high -> response stable, both ready low, busy=1; rsp_ready=1 -> IDLE.
REQ-037 260 consecutive error ops -> err_cnt stops at 255; err_clr coincident with an error response -> err_cnt=0.
REQ-038 rst pulsed mid-EXEC -> no rsp_valid; all outputs at reset values; pointer back to 0 (req0 wins the next tie).

Source files
------------

// File: rtl/bit_set_arbiter.sv
// bit_set_arbiter: two requesters share one "set bit B in A" unit.
// Round-robin tie-break, IDLE -> EXEC -> RESP handshake, and a
// saturating counter of out-of-range (error) responses.
module bit_set_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic         rsp_error,
  output logic         busy,
  output logic [7:0]   err_cnt,
  input  logic         err_clr
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  // N as an (N+1)-bit constant so the range check compares equal widths
  localparam logic [N:0] N_EXT = (N + 1)'(N);

  state_t       state;
  state_t       state_nxt;
  logic         ptr;
  logic         grant0;
  logic         grant1;
  logic         accept;
  logic         win_id;
  logic [N-1:0] cap_a;
  logic [N-1:0] cap_b;
  logic         in_range;
  logic [N-1:0] set_val;

  // Arbitration: lone valid wins, ties go to the requester named by ptr
  always_comb begin
    grant0     = req0_valid && (!req1_valid || !ptr);
    grant1     = req1_valid && (!req0_valid ||  ptr);
    req0_ready = (state == IDLE) && grant0;
    req1_ready = (state == IDLE) && grant1;
    accept     = req0_ready || req1_ready;
    win_id     = grant1;
    in_range   = ({1'b0, cap_b} < N_EXT);
    set_val    = cap_a | (N'(1) << cap_b);
    rsp_valid  = (state == RESP);
    busy       = (state != IDLE);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Capture on accept, compute result in EXEC, count errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= 1'b0;
      cap_a      <= '0;
      cap_b      <= '0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_error  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      if (accept) begin
        cap_a  <= win_id ? req1_a : req0_a;
        cap_b  <= win_id ? req1_b : req0_b;
        rsp_id <= win_id;
        ptr    <= ~win_id;
      end
      if (state == EXEC) begin
        rsp_result <= in_range ? set_val : cap_a;
        rsp_error  <= !in_range;
      end
      if (err_clr)
        err_cnt <= '0;
      else if ((state == EXEC) && !in_range && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
